// File: rtl/vga_pattern_gen.sv
// Test-pattern generator that sits behind the VGA sync generator: recovers x/y from sync edges,
// emits 12-bit RGB plus data-enable, and re-times hsyn/vsyn so everything leaves aligned 2 clocks later.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BAR_W    = 80,
    parameter int CNT_W    = 10
) (
    input  logic        clk,
    input  logic        greset,
    input  logic        hsyn,
    input  logic        vsyn,
    input  logic [1:0]  mode,
    input  logic [11:0] solid_rgb,
    output logic        hsyn_o,
    output logic        vsyn_o,
    output logic        de,
    output logic [11:0] rgb,
    output logic        locked
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] H_LIM   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LIM   = CNT_W'(V_ACTIVE);

    logic             hs_q, hs_d, vs_q, vs_d;
    logic             hs_o_q, hs_o_d, vs_o_q, vs_o_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             arm_q, arm_d;
    logic [1:0]       mode_q, mode_d;
    logic [11:0]      solid_q, solid_d;
    logic             seen_q, seen_d;
    logic             locked_q, locked_d;
    logic             de_q, de_d;
    logic [11:0]      rgb_q, rgb_d;

    logic             h_rise, v_rise, arm_now, active;
    logic [2:0]       bar_idx;
    logic [11:0]      bar_rgb, pat_rgb;

    always_comb begin
        hs_d   = hsyn;
        vs_d   = vsyn;
        hs_o_d = hs_q;
        vs_o_d = vs_q;

        // The output-stage sync flops double as the "previous sample" for edge detection.
        h_rise = hs_q & ~hs_o_q;
        v_rise = vs_q & ~vs_o_q;

        x_d = h_rise ? '0 : ((x_q == CNT_MAX) ? x_q : x_q + 1'b1);

        arm_now = arm_q | v_rise;
        arm_d   = arm_now;
        y_d     = y_q;
        if (h_rise) begin
            arm_d = 1'b0;
            y_d   = arm_now ? '0 : ((y_q == CNT_MAX) ? y_q : y_q + 1'b1);
        end

        mode_d  = v_rise ? mode      : mode_q;
        solid_d = v_rise ? solid_rgb : solid_q;

        seen_d   = seen_q;
        locked_d = locked_q;
        if (x_d == CNT_MAX) begin
            locked_d = 1'b0;
            seen_d   = 1'b0;
        end else if (v_rise && !locked_q) begin
            if (seen_q) locked_d = 1'b1;
            else        seen_d   = 1'b1;
        end

        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x_d >= CNT_W'(BAR_W * i)) bar_idx = 3'(i);
        end
        case (bar_idx)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase

        case (mode_d)
            2'd0:    pat_rgb = bar_rgb;
            2'd1:    pat_rgb = (x_d[5] ^ y_d[5]) ? 12'hFFF : 12'h000;
            2'd2:    pat_rgb = {x_d[9:6], y_d[8:5], 4'h0};
            default: pat_rgb = solid_d;
        endcase

        active = (x_d < H_LIM) && (y_d < V_LIM) && locked_d;
        de_d   = active;
        rgb_d  = active ? pat_rgb : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (greset) begin
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            hs_o_q   <= 1'b0;
            vs_o_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            arm_q    <= 1'b0;
            mode_q   <= 2'd0;
            solid_q  <= 12'h000;
            seen_q   <= 1'b0;
            locked_q <= 1'b0;
            de_q     <= 1'b0;
            rgb_q    <= 12'h000;
        end else begin
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            hs_o_q   <= hs_o_d;
            vs_o_q   <= vs_o_d;
            x_q      <= x_d;
            y_q      <= y_d;
            arm_q    <= arm_d;
            mode_q   <= mode_d;
            solid_q  <= solid_d;
            seen_q   <= seen_d;
            locked_q <= locked_d;
            de_q     <= de_d;
            rgb_q    <= rgb_d;
        end
    end

    assign hsyn_o = hs_o_q;
    assign vsyn_o = vs_o_q;
    assign de     = de_q;
    assign rgb    = rgb_q;
    assign locked = locked_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: drives sync timing with randomized short lines, predicts every output
// cycle from a pixel-timeline model, and checks it through a queue consumed by a separate monitor.
module tb_vga_pattern_gen;
    logic        clk = 1'b0;
    logic        greset, hsyn, vsyn;
    logic [1:0]  mode;
    logic [11:0] solid_rgb;
    logic        hsyn_o, vsyn_o, de, locked;
    logic [11:0] rgb;

    vga_pattern_gen dut (
        .clk(clk), .greset(greset), .hsyn(hsyn), .vsyn(vsyn),
        .mode(mode), .solid_rgb(solid_rgb),
        .hsyn_o(hsyn_o), .vsyn_o(vsyn_o), .de(de), .rgb(rgb), .locked(locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          t;
        logic        hs, vs, de, lk;
        logic [11:0] rgb;
        string       ph;
    } exp_t;

    exp_t  q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "reset";

    // Reference model state, on the input timeline
    int         mx, my, mnv;
    bit         mph, mpv, marm, mlocked;
    bit [1:0]   mmode;
    bit [11:0]  msolid;
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    function automatic exp_t zero_exp(int t);
        exp_t e;
        e.t = t; e.hs = 0; e.vs = 0; e.de = 0; e.lk = 0; e.rgb = 12'h000; e.ph = phase;
        return e;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mnv = 0;
        mph = 0; mpv = 0; marm = 0; mlocked = 0;
        mmode = 0; msolid = 0;
    endtask

    task automatic model_step(input bit h, input bit v, output exp_t e);
        bit hr, vr, act;
        logic [11:0] pix;
        hr = h && !mph;
        vr = v && !mpv;
        mph = h; mpv = v;
        mx = hr ? 0 : ((mx < 1023) ? mx + 1 : 1023);
        if (vr) begin
            marm = 1; mmode = mode; msolid = solid_rgb;
        end
        if (hr) begin
            if (marm) begin my = 0; marm = 0; end
            else if (my < 1023) my++;
        end
        if (mx == 1023) begin
            mlocked = 0; mnv = 0;
        end else if (vr && !mlocked) begin
            mnv++;
            if (mnv >= 2) mlocked = 1;
        end
        act = (mx < 640) && (my < 480) && mlocked;
        case (mmode)
            2'd0:    pix = act ? bars[mx / 80] : 12'h000;
            2'd1:    pix = (((mx / 32) % 2) != ((my / 32) % 2)) ? 12'hFFF : 12'h000;
            2'd2:    pix = {4'((mx / 64) % 16), 4'((my / 32) % 16), 4'h0};
            default: pix = msolid;
        endcase
        e.hs = h; e.vs = v; e.de = act; e.lk = mlocked;
        e.rgb = act ? pix : 12'h000;
        e.ph = phase;
    endtask

    // One input cycle: drive, predict, then advance to just after the next rising edge.
    task automatic cycle(input bit h, input bit v, input bit r);
        exp_t e;
        greset = r; hsyn = h; vsyn = v;
        if (r) begin
            model_reset();
            if (q.size() > 0 && q[$].t == cyc + 1) void'(q.pop_back());
            q.push_back(zero_exp(cyc + 1));
            q.push_back(zero_exp(cyc + 2));
        end else begin
            model_step(h, v, e);
            e.t = cyc + 2;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int len, input int low, input bit v, input int stall_at, input int rst_at);
        for (int h = 0; h < len; h++) begin
            if (h == stall_at)
                for (int s = 0; s < 1100; s++) cycle(1'b1, v, 1'b0);
            if (h == rst_at) cycle(h < len - low, v, 1'b1);
            cycle(h < len - low, v, 1'b0);
        end
    endtask

    task automatic run_frame(input int n_lines, input int v_low, input int extra_long,
                             input int stall_line, input int rst_line,
                             input int mode_line, input logic [1:0] new_mode, input logic [11:0] new_solid);
        for (int l = 0; l < n_lines; l++) begin
            bit v;
            v = (l < n_lines - v_low);
            if (l == mode_line) begin
                mode = new_mode; solid_rgb = new_solid;
            end
            if (l < 2 || l == extra_long)
                run_line(800, 160, v, (l == stall_line) ? 100 : -1, (l == rst_line) ? 300 : -1);
            else
                run_line(int'($urandom_range(40, 16)), int'($urandom_range(6, 2)), v, -1, -1);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].t < cyc) begin
            exp_t s;
            s = q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL stale_expectation [%s] t=%0d never compared (now %0d)", s.ph, s.t, cyc);
        end
        if (q.size() > 0 && q[0].t == cyc) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (hsyn_o !== e.hs || vsyn_o !== e.vs || de !== e.de || rgb !== e.rgb || locked !== e.lk) begin
                n_fail++;
                $display("FAIL outputs [%s] cyc=%0d got hs=%b vs=%b de=%b rgb=%h lk=%b, want hs=%b vs=%b de=%b rgb=%h lk=%b",
                         e.ph, cyc, hsyn_o, vsyn_o, de, rgb, locked, e.hs, e.vs, e.de, e.rgb, e.lk);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not complete (cyc=%0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        model_reset();
        mode = 2'd0; solid_rgb = 12'h000;
        repeat (5) cycle(1'b0, 1'b0, 1'b1);

        phase = "frame1_unlocked";
        run_frame(40, 4, -1, -1, -1, -1, 2'd0, 12'h000);
        phase = "frame2_bars_vlimit_mode_change";
        run_frame(500, 20, 25, -1, -1, 20, 2'd3, 12'hA5C);
        phase = "frame3_solid";
        run_frame(40, 4, -1, -1, -1, 10, 2'd1, 12'(($urandom)));
        phase = "frame4_checker";
        run_frame(40, 4, 32, -1, -1, 10, 2'd2, 12'h000);
        phase = "frame5_gradient_stall";
        run_frame(40, 4, -1, 1, -1, 10, 2'($urandom_range(3, 0)), 12'(($urandom)));
        phase = "frame6_relock_arm";
        run_frame(40, 4, -1, -1, -1, -1, 2'd0, 12'h000);
        phase = "frame7_relocked";
        run_frame(40, 4, -1, -1, -1, 10, 2'($urandom_range(3, 0)), 12'(($urandom)));
        phase = "frame8_midline_reset";
        run_frame(40, 4, 37, -1, 37, -1, 2'd0, 12'h000);
        phase = "frame9_after_reset";
        run_frame(40, 4, -1, -1, -1, 10, 2'($urandom_range(3, 0)), 12'(($urandom)));
        phase = "frame10_relock";
        run_frame(40, 4, -1, -1, -1, 10, 2'($urandom_range(3, 0)), 12'(($urandom)));
        phase = "frame11_random";
        run_frame(40, 4, -1, -1, -1, -1, 2'd0, 12'h000);

        phase = "drain";
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Downstream consumer of the VGA sync generator. Takes its free-running hsyn/vsyn, recovers pixel x/y by edge-counting, and produces registered 12-bit RGB test patterns plus data-enable. Sync is re-emitted with matching latency so the colour and timing outputs reach the DAC/connector aligned. A lock flag suppresses video until a full frame of valid timing has been seen.

Parameters:
H_ACTIVE, 640, active pixels per line, counted from hsyn rise
V_ACTIVE, 480, active lines per frame, counted from vsyn rise
BAR_W, 80, colour-bar width in pixels (H_ACTIVE/8)
CNT_W, 10, width of the internal x/y counters

Ports:
clk  in  1  pixel clock, same clock as the sync generator
greset  in  1  synchronous reset, active-high
hsyn  in  1  line sync from the upstream generator; low for 160 of every 800 clocks
vsyn  in  1  frame sync from the upstream generator; low for 20 of every 500 lines
mode  in  2  pattern select: 0 bars, 1 checker, 2 gradient, 3 solid
solid_rgb  in  12  colour used in mode 3, as {R[3:0],G[3:0],B[3:0]}
hsyn_o  out  1  hsyn delayed exactly 2 clocks
vsyn_o  out  1  vsyn delayed exactly 2 clocks
de  out  1  active-video flag, aligned with hsyn_o/vsyn_o
rgb  out  12  pixel colour, aligned with de
locked  out  1  timing lock indicator

Behaviour:
- Single clock domain. greset is sampled on the clk rising edge only.
- On reset: hsyn_o=0, vsyn_o=0, de=0, rgb=0, locked=0; x/y counters=0; mode and solid registers=0.
- Edge detection:
  - hsyn and vsyn are registered once.
  - A rise is a current sample of 1 where the previous sample was 0.
- x (input timeline):
  - x=0 on the first clock where hsyn is high after being low.
  - x increments by 1 each clock and saturates at 2^CNT_W-1.
  - Every hsyn rise restarts x at 0.
- y:
  - A vsyn rise arms a frame restart.
  - The hsyn rise in the same input cycle as the arming vsyn rise, or the first one after it, sets y=0 and clears the arm.
  - Every other hsyn rise increments y, saturating at 2^CNT_W-1.
- Active window: x < H_ACTIVE and y < V_ACTIVE and locked=1.
- Frame-start register update: on each vsyn rise, mode and solid_rgb are captured. Patterns never change mid-frame.
- Lock:
  - locked sets on the second vsyn rise after reset or after loss.
  - locked clears when x reaches 2^CNT_W-1, i.e. no hsyn rise for 1023 clocks. The lock process then restarts from zero vsyn rises.
- Latency: the pixel at input-timeline (x,y) appears on de/rgb exactly 2 clocks later, the same cycle hsyn_o/vsyn_o show that input's sync values. All outputs are registered.
- Outside the active window: de=0, rgb=12'h000. hsyn_o/vsyn_o always pass through, locked or not.
- Patterns (captured mode):
  - 0, colour bars: bar = x/BAR_W via compares, no divider. Bars 0..7 are FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - 1, checkerboard: rgb = (x[5]^y[5]) ? FFF : 000.
  - 2, gradient: R=x[9:6], G=y[8:5], B=0.
  - 3, solid: rgb = captured solid_rgb.
- Reset mid-frame: all state clears the next edge. Video stays blanked until two new vsyn rises have been seen.

Test Plan:
1. Reset 5 clocks, then drive standard timing (800x500, hsyn low 160, vsyn low 20). Required: locked=0 and de=0 through frame 1; locked=1 at the start of frame 2; de high for exactly 640 clocks per line on 480 lines; de first asserts 2 clocks after the input hsyn rise.
2. mode=0 on a locked frame. Required: rgb=FFF for x=0..79, FF0 for x=80..159, and so on through 000 for x=560..639; rgb=000 at x=640.
3. mode=1. Required: at line y=0, x=31 gives 000 and x=32 gives FFF; at line y=32, x=0 gives FFF.
4. Change mode from 0 to 3 mid-frame with solid_rgb=12'hA5C. Required: bars persist until the next vsyn rise; every active pixel of the following frame is A5C.
5. Hold hsyn high for 1100 clocks. Required: locked drops when x reaches 1023 and de=0 thereafter; after timing resumes, relock on the second vsyn rise.
6. Assert greset mid-line while de=1. Required: next cycle all outputs are 0; re-lock occurs only after two vsyn rises; hsyn_o tracks hsyn with 2-clock delay immediately after reset releases.
